// File: rtl/deser_align_pkg.sv
// Shared types, constants and helpers for the deserializer word-alignment controller.
package deser_align_pkg;

    localparam int SYM_W = 10;
    localparam logic [SYM_W-1:0] K28_5_RDN = 10'b0011111010;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        BLANK  = 2'd1,
        VERIFY = 2'd2,
        LOCKED = 2'd3
    } align_state_e;

    // Either running disparity of the comma symbol counts as a boundary hit.
    function automatic logic is_sync(input logic [SYM_W-1:0] sym, input logic [SYM_W-1:0] sync);
        return (sym == sync) || (sym == ~sync);
    endfunction

    function automatic int cnt_w(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/deser_align_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over increment).
module sat_counter #(
    parameter int W   = 4,
    parameter int MAX = 15
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    localparam logic [W-1:0] MAX_V = W'(MAX);
    localparam logic [W-1:0] ONE_V = W'(1'b1);

    logic [W-1:0] cnt_r;

    // Count register: clear, saturating increment, or hold.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_r <= '0;
        end else if (clr) begin
            cnt_r <= '0;
        end else if (inc && (cnt_r != MAX_V)) begin
            cnt_r <= cnt_r + ONE_V;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign cnt = cnt_r;

endmodule

// File: rtl/deser_align_ctrl.sv
// Word-alignment controller: slips the deserializer until sync symbols line up, then gates symbols to the decoder.
// Optional statistics outputs (slip_count, lock_loss_count) are built when DESER_ALIGN_STATS_EN is defined.
module deser_align_ctrl
    import deser_align_pkg::*;
#(
    parameter int                    DATA_WIDTH = 10,
    parameter logic [DATA_WIDTH-1:0] SYNC_WORD  = K28_5_RDN,
    parameter int                    LOCK_CNT   = 4,
    parameter int                    UNLOCK_ERR = 4,
    parameter int                    GOOD_RUN   = 16,
    parameter int                    SLIP_BLANK = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic [DATA_WIDTH-1:0] sym_in,
    input  logic                  sym_valid,
    input  logic                  code_err,
    output logic                  bit_slip,
    output logic                  locked,
    output logic [DATA_WIDTH-1:0] sym_out,
    output logic                  sym_out_valid,
    output logic [1:0]            state_o
`ifdef DESER_ALIGN_STATS_EN
    ,
    output logic [15:0]           slip_count,
    output logic [7:0]            lock_loss_count
`endif
);

    localparam int MW = cnt_w(LOCK_CNT);
    localparam int EW = cnt_w(UNLOCK_ERR);
    localparam int GW = cnt_w(GOOD_RUN);
    localparam int BW = cnt_w(SLIP_BLANK);

    localparam logic [MW-1:0] MATCH_LAST = MW'(LOCK_CNT - 1);
    localparam logic [EW-1:0] ERR_LAST   = EW'(UNLOCK_ERR - 1);
    localparam logic [GW-1:0] GOOD_LAST  = GW'(GOOD_RUN - 1);
    localparam logic [BW-1:0] BLANK_LAST = BW'((SLIP_BLANK > 0) ? SLIP_BLANK - 1 : 0);

    align_state_e          state_r, state_next_s;
    logic                  bit_slip_r, locked_r, sym_out_valid_r;
    logic [DATA_WIDTH-1:0] sym_out_r;

    logic                  match_s, slip_next_s, fwd_s, unlock_s;
    logic                  match_inc_s, match_clr_s, blank_inc_s, blank_clr_s;
    logic                  err_inc_s, err_clr_s, good_inc_s, good_clr_s;
    logic [MW-1:0]         match_cnt_s;
    logic [EW-1:0]         err_cnt_s;
    logic [GW-1:0]         good_cnt_s;
    logic [BW-1:0]         blank_cnt_s;

    sat_counter #(.W(MW), .MAX(LOCK_CNT)) u_match_cnt (
        .clk(clk), .rst(rst), .clr(match_clr_s), .inc(match_inc_s), .cnt(match_cnt_s));
    sat_counter #(.W(EW), .MAX(UNLOCK_ERR)) u_err_cnt (
        .clk(clk), .rst(rst), .clr(err_clr_s), .inc(err_inc_s), .cnt(err_cnt_s));
    sat_counter #(.W(GW), .MAX(GOOD_RUN)) u_good_cnt (
        .clk(clk), .rst(rst), .clr(good_clr_s), .inc(good_inc_s), .cnt(good_cnt_s));
    sat_counter #(.W(BW), .MAX(SLIP_BLANK)) u_blank_cnt (
        .clk(clk), .rst(rst), .clr(blank_clr_s), .inc(blank_inc_s), .cnt(blank_cnt_s));

    // Next-state, slip/forward decisions and counter controls.
    always_comb begin
        state_next_s = state_r;
        slip_next_s  = 1'b0;
        fwd_s        = 1'b0;
        unlock_s     = 1'b0;
        match_inc_s  = 1'b0;
        match_clr_s  = 1'b0;
        blank_inc_s  = 1'b0;
        blank_clr_s  = 1'b0;
        err_inc_s    = 1'b0;
        err_clr_s    = 1'b0;
        good_inc_s   = 1'b0;
        good_clr_s   = 1'b0;
        match_s      = is_sync(sym_in, SYNC_WORD);

        if (!enable) begin
            state_next_s = HUNT;
            match_clr_s  = 1'b1;
            blank_clr_s  = 1'b1;
            err_clr_s    = 1'b1;
            good_clr_s   = 1'b1;
        end else begin
            case (state_r)
                HUNT: begin
                    blank_clr_s = 1'b1;
                    err_clr_s   = 1'b1;
                    good_clr_s  = 1'b1;
                    if (sym_valid && match_s) begin
                        match_inc_s  = 1'b1;
                        state_next_s = (match_cnt_s == MATCH_LAST) ? LOCKED : VERIFY;
                    end else if (sym_valid) begin
                        match_clr_s  = 1'b1;
                        slip_next_s  = 1'b1;
                        state_next_s = BLANK;
                    end else begin
                        state_next_s = HUNT;
                    end
                end
                BLANK: begin
                    match_clr_s = 1'b1;
                    err_clr_s   = 1'b1;
                    good_clr_s  = 1'b1;
                    blank_inc_s = sym_valid;
                    if ((SLIP_BLANK == 0) || (sym_valid && (blank_cnt_s == BLANK_LAST))) begin
                        blank_clr_s  = 1'b1;
                        state_next_s = HUNT;
                    end else begin
                        state_next_s = BLANK;
                    end
                end
                VERIFY: begin
                    blank_clr_s = 1'b1;
                    err_clr_s   = 1'b1;
                    good_clr_s  = 1'b1;
                    if (sym_valid && match_s) begin
                        match_inc_s  = 1'b1;
                        state_next_s = (match_cnt_s == MATCH_LAST) ? LOCKED : VERIFY;
                    end else if (sym_valid) begin
                        // No slip here: a broken run only restarts the hunt at this boundary.
                        match_clr_s  = 1'b1;
                        state_next_s = HUNT;
                    end else begin
                        state_next_s = VERIFY;
                    end
                end
                LOCKED: begin
                    match_clr_s = 1'b1;
                    blank_clr_s = 1'b1;
                    if (code_err) begin
                        err_inc_s  = 1'b1;
                        good_clr_s = 1'b1;
                        unlock_s   = (err_cnt_s == ERR_LAST);
                    end else if (sym_valid) begin
                        good_inc_s = 1'b1;
                        if (good_cnt_s == GOOD_LAST) begin
                            good_clr_s = 1'b1;
                            err_clr_s  = 1'b1;
                        end else begin
                            good_clr_s = 1'b0;
                        end
                    end else begin
                        good_inc_s = 1'b0;
                    end
                    if (unlock_s) begin
                        err_clr_s    = 1'b1;
                        state_next_s = HUNT;
                    end else begin
                        fwd_s        = sym_valid;
                        state_next_s = LOCKED;
                    end
                end
                default: begin
                    state_next_s = HUNT;
                    match_clr_s  = 1'b1;
                    blank_clr_s  = 1'b1;
                    err_clr_s    = 1'b1;
                    good_clr_s   = 1'b1;
                end
            endcase
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r         <= HUNT;
            bit_slip_r      <= 1'b0;
            locked_r        <= 1'b0;
            sym_out_valid_r <= 1'b0;
            sym_out_r       <= '0;
        end else begin
            state_r         <= state_next_s;
            bit_slip_r      <= slip_next_s;
            locked_r        <= (state_next_s == LOCKED);
            sym_out_valid_r <= fwd_s;
            if (fwd_s) begin
                sym_out_r <= sym_in;
            end else begin
                sym_out_r <= sym_out_r;
            end
        end
    end

    assign bit_slip      = bit_slip_r;
    assign locked        = locked_r;
    assign sym_out       = sym_out_r;
    assign sym_out_valid = sym_out_valid_r;
    assign state_o       = state_r;

`ifdef DESER_ALIGN_STATS_EN
    sat_counter #(.W(16), .MAX(65535)) u_slip_stat (
        .clk(clk), .rst(rst), .clr(1'b0), .inc(slip_next_s), .cnt(slip_count));
    sat_counter #(.W(8), .MAX(255)) u_loss_stat (
        .clk(clk), .rst(rst), .clr(1'b0), .inc(unlock_s), .cnt(lock_loss_count));
`endif

endmodule

// File: tb/tb_deser_align_ctrl.sv
// Directed self-checking bench for deser_align_ctrl (default parameters).
module tb_deser_align_ctrl;

    localparam logic [9:0] SYNC  = 10'b0011111010;
    localparam logic [9:0] NSYNC = 10'b1100000101;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic [9:0] sym_in;
    logic       sym_valid;
    logic       code_err;
    logic       bit_slip;
    logic       locked;
    logic [9:0] sym_out;
    logic       sym_out_valid;
    logic [1:0] state_o;
`ifdef DESER_ALIGN_STATS_EN
    logic [15:0] slip_count;
    logic [7:0]  lock_loss_count;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    int slip_seen = 0;

    deser_align_ctrl dut (
        .clk(clk), .rst(rst), .enable(enable), .sym_in(sym_in), .sym_valid(sym_valid),
        .code_err(code_err), .bit_slip(bit_slip), .locked(locked), .sym_out(sym_out),
        .sym_out_valid(sym_out_valid), .state_o(state_o)
`ifdef DESER_ALIGN_STATS_EN
        , .slip_count(slip_count), .lock_loss_count(lock_loss_count)
`endif
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bit_slip === 1'b1) slip_seen++;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic [9:0] s, input logic v, input logic e);
        sym_in    = s;
        sym_valid = v;
        code_err  = e;
        @(posedge clk);
        #1;
        sym_valid = 1'b0;
        code_err  = 1'b0;
    endtask

    function automatic logic [9:0] rotl(input logic [9:0] v, input int k);
        return (v << k) | (v >> (10 - k));
    endfunction

    initial begin
        int off;
        int n;
        int base;
        rst = 1'b0; enable = 1'b1; sym_in = 10'h000; sym_valid = 1'b0; code_err = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_state", state_o, 16'd0);
        chk("rst_locked", locked, 16'd0);
        chk("rst_slip", bit_slip, 16'd0);
        chk("rst_symv", sym_out_valid, 16'd0);
        chk("rst_sym", sym_out, 16'd0);
        rst = 1'b1;

        // Aligned stream
        step(SYNC, 1'b1, 1'b0);
        step(SYNC, 1'b1, 1'b0);
        step(SYNC, 1'b1, 1'b0);
        chk("al_verify_state", state_o, 16'd2);
        chk("al_not_locked", locked, 16'd0);
        step(SYNC, 1'b1, 1'b0);
        chk("al_locked", locked, 16'd1);
        chk("al_state", state_o, 16'd3);
        chk("al_no_slip", slip_seen, 16'd0);
        step(10'h2AA, 1'b1, 1'b0);
        chk("fwd_valid", sym_out_valid, 16'd1);
        chk("fwd_data", sym_out, 16'h2AA);
        step(10'h000, 1'b0, 1'b0);
        chk("fwd_idle", sym_out_valid, 16'd0);

        // Error loss
        step(10'h111, 1'b1, 1'b1);
        step(10'h112, 1'b1, 1'b0);
        step(10'h113, 1'b1, 1'b1);
        step(10'h114, 1'b1, 1'b0);
        step(10'h115, 1'b1, 1'b1);
        chk("el_still_locked", locked, 16'd1);
        chk("el_err_fwd", sym_out_valid, 16'd1);
        chk("el_err_data", sym_out, 16'h115);
        step(10'h116, 1'b1, 1'b1);
        chk("el_unlocked", locked, 16'd0);
        chk("el_hunt", state_o, 16'd0);
        chk("el_no_fwd", sym_out_valid, 16'd0);

        // VERIFY break (complement also matches)
        step(SYNC, 1'b1, 1'b0);
        step(NSYNC, 1'b1, 1'b0);
        chk("vb_verify", state_o, 16'd2);
        step(10'h155, 1'b1, 1'b0);
        chk("vb_hunt", state_o, 16'd0);
        chk("vb_no_slip", bit_slip, 16'd0);
        step(10'h155, 1'b1, 1'b0);
        chk("vb_slip", bit_slip, 16'd1);
        chk("vb_blank", state_o, 16'd1);
        step(10'h155, 1'b1, 1'b0);
        chk("bl_no_slip", bit_slip, 16'd0);
        chk("bl_still_blank", state_o, 16'd1);
        step(10'h155, 1'b1, 1'b0);
        chk("bl_back_hunt", state_o, 16'd0);
        chk("bl_no_slip2", bit_slip, 16'd0);

        // Misaligned stream rotated by 3 bits
        off = 3;
        n = 0;
        base = slip_seen;
        for (int i = 0; i < 40 && locked !== 1'b1; i++) begin
            step(rotl(SYNC, off), 1'b1, 1'b0);
            n++;
            if (bit_slip === 1'b1 && off > 0) off--;
        end
        chk("mis_slips", 16'(slip_seen - base), 16'd3);
        chk("mis_strobes", 16'(n), 16'd13);
        chk("mis_locked", locked, 16'd1);
        chk("mis_offset", 16'(off), 16'd0);
`ifdef DESER_ALIGN_STATS_EN
        chk("st_slip_count", slip_count, 16'd4);
`endif

        // Error recovery
        repeat (3) step(10'h0F0, 1'b1, 1'b1);
        for (int i = 0; i < 16; i++) step(10'h0F1, 1'b1, 1'b0);
        repeat (3) step(10'h0F2, 1'b1, 1'b1);
        chk("rec_locked", locked, 16'd1);
        chk("rec_state", state_o, 16'd3);
        step(10'h0F3, 1'b1, 1'b1);
        chk("rec_unlock", locked, 16'd0);
`ifdef DESER_ALIGN_STATS_EN
        chk("st_loss_count", lock_loss_count, 16'd2);
`endif

        // enable low during VERIFY
        step(SYNC, 1'b1, 1'b0);
        step(SYNC, 1'b1, 1'b0);
        chk("en_verify", state_o, 16'd2);
        enable = 1'b0;
        step(SYNC, 1'b1, 1'b0);
        chk("en_hunt", state_o, 16'd0);
        chk("en_locked", locked, 16'd0);
        step(10'h155, 1'b1, 1'b0);
        chk("en_slip_supp", bit_slip, 16'd0);
        chk("en_hold_hunt", state_o, 16'd0);
        enable = 1'b1;
        step(SYNC, 1'b1, 1'b0);
        step(SYNC, 1'b1, 1'b0);
        chk("en_cnt_cleared", state_o, 16'd2);
`ifdef DESER_ALIGN_STATS_EN
        chk("st_slip_hold", slip_count, 16'd4);
`endif
        step(SYNC, 1'b1, 1'b0);
        step(SYNC, 1'b1, 1'b0);
        chk("relock", locked, 16'd1);
        step(10'h3AB, 1'b1, 1'b0);
        chk("relock_fwd", sym_out, 16'h3AB);

        // Asynchronous reset mid-stream while locked
        sym_in = 10'h0CC;
        sym_valid = 1'b1;
        #2;
        rst = 1'b0;
        #1;
        chk("ar_state", state_o, 16'd0);
        chk("ar_locked", locked, 16'd0);
        chk("ar_symv", sym_out_valid, 16'd0);
        chk("ar_sym", sym_out, 16'd0);
        @(posedge clk);
        #1;
        chk("ar_no_partial", sym_out_valid, 16'd0);
`ifdef DESER_ALIGN_STATS_EN
        chk("st_slip_rst", slip_count, 16'd0);
        chk("st_loss_rst", lock_loss_count, 16'd0);
`endif
        sym_valid = 1'b0;
        rst = 1'b1;
        step(10'h000, 1'b0, 1'b0);
        chk("post_rst_hunt", state_o, 16'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
